// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Decode, write-back and execute-stage signal bundle for the
//               RV32I decode-to-execute pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);
    logic              valid_d;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   pc4_d;
    logic [AW-1:0]     rs1_d;
    logic [AW-1:0]     rs2_d;
    logic [AW-1:0]     rd_d;
    logic              uses_rs1_d;
    logic              uses_rs2_d;
    logic [XLEN-1:0]   imm_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              load_d;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              stall;
    logic              flush;

    logic              ready_d;
    logic              hazard;
    logic              valid_e;
    logic [XLEN-1:0]   pc_e;
    logic [XLEN-1:0]   pc4_e;
    logic [XLEN-1:0]   imm_e;
    logic [XLEN-1:0]   rd_e1;
    logic [XLEN-1:0]   rd_e2;
    logic [AW-1:0]     rs_e1;
    logic [AW-1:0]     rs_e2;
    logic [AW-1:0]     rd_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic              load_e;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output valid_d, pc_d, pc4_d, rs1_d, rs2_d, rd_d, uses_rs1_d, uses_rs2_d,
               imm_d, ctrl_d, load_d, wb_en, wb_addr, wb_data, stall, flush,
        input  ready_d, hazard, valid_e, pc_e, pc4_e, imm_e, rd_e1, rd_e2,
               rs_e1, rs_e2, rd_e, ctrl_e, load_e, bubble_cnt
    );

    modport slave (
        input  valid_d, pc_d, pc4_d, rs1_d, rs2_d, rd_d, uses_rs1_d, uses_rs2_d,
               imm_d, ctrl_d, load_d, wb_en, wb_addr, wb_data, stall, flush,
        output ready_d, hazard, valid_e, pc_e, pc4_e, imm_e, rd_e1, rd_e2,
               rs_e1, rs_e2, rd_e, ctrl_e, load_e, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : RV32I decode-to-execute stage: register file with write-back
//               bypass, load-use bubble insertion, execute pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,     // active-low, asynchronous assert
    id_ex_stage_if.slave   bus
);

    localparam logic [XLEN-1:0]   c_xzero   = '0;
    localparam logic [AW-1:0]     c_azero   = '0;
    localparam logic [CTRL_W-1:0] c_czero   = '0;
    localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_max = '1;

    logic [XLEN-1:0]   r_rf [NREG];

    logic              r_valid_e;
    logic [XLEN-1:0]   r_pc_e;
    logic [XLEN-1:0]   r_pc4_e;
    logic [XLEN-1:0]   r_imm_e;
    logic [XLEN-1:0]   r_rd_e1;
    logic [XLEN-1:0]   r_rd_e2;
    logic [AW-1:0]     r_rs_e1;
    logic [AW-1:0]     r_rs_e2;
    logic [AW-1:0]     r_rd_e;
    logic [CTRL_W-1:0] r_ctrl_e;
    logic              r_load_e;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    logic              w_hazard;
    logic              w_rs1_match;
    logic              w_rs2_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_addr != c_azero)) begin
            r_rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Write-first read: a same-cycle write-back overrides the stored value.
    always_comb begin
        w_rs1_val = r_rf[bus.rs1_d];
        w_rs2_val = r_rf[bus.rs2_d];
        if (bus.wb_en && (bus.wb_addr == bus.rs1_d)) w_rs1_val = bus.wb_data;
        if (bus.wb_en && (bus.wb_addr == bus.rs2_d)) w_rs2_val = bus.wb_data;
        if (bus.rs1_d == c_azero) w_rs1_val = c_xzero;
        if (bus.rs2_d == c_azero) w_rs2_val = c_xzero;
    end

    // The bypass never clears a hazard: the load result is not yet available.
    assign w_rs1_match = bus.uses_rs1_d && (bus.rs1_d == r_rd_e);
    assign w_rs2_match = bus.uses_rs2_d && (bus.rs2_d == r_rd_e);
    assign w_hazard    = bus.valid_d && r_valid_e && r_load_e && (r_rd_e != c_azero)
                         && (w_rs1_match || w_rs2_match);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_e <= 1'b0;
            r_pc_e    <= c_xzero;
            r_pc4_e   <= c_xzero;
            r_imm_e   <= c_xzero;
            r_rd_e1   <= c_xzero;
            r_rd_e2   <= c_xzero;
            r_rs_e1   <= c_azero;
            r_rs_e2   <= c_azero;
            r_rd_e    <= c_azero;
            r_ctrl_e  <= c_czero;
            r_load_e  <= 1'b0;
        end else if (bus.flush || (!bus.stall && w_hazard)) begin
            r_valid_e <= 1'b0;
            r_pc_e    <= c_xzero;
            r_pc4_e   <= c_xzero;
            r_imm_e   <= c_xzero;
            r_rd_e1   <= c_xzero;
            r_rd_e2   <= c_xzero;
            r_rs_e1   <= c_azero;
            r_rs_e2   <= c_azero;
            r_rd_e    <= c_azero;
            r_ctrl_e  <= c_czero;
            r_load_e  <= 1'b0;
        end else if (!bus.stall) begin
            r_valid_e <= bus.valid_d;
            r_pc_e    <= bus.pc_d;
            r_pc4_e   <= bus.pc4_d;
            r_imm_e   <= bus.imm_d;
            r_rd_e1   <= w_rs1_val;
            r_rd_e2   <= w_rs2_val;
            r_rs_e1   <= bus.rs1_d;
            r_rs_e2   <= bus.rs2_d;
            r_rd_e    <= bus.rd_d;
            r_ctrl_e  <= bus.valid_d ? bus.ctrl_d : c_czero;
            r_load_e  <= bus.valid_d && bus.load_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
        end else if (!bus.flush && !bus.stall && w_hazard && (r_bubble_cnt != c_cnt_max)) begin
            r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
        end
    end

    assign bus.hazard     = w_hazard;
    assign bus.ready_d    = !bus.stall && !w_hazard && !bus.flush;
    assign bus.valid_e    = r_valid_e;
    assign bus.pc_e       = r_pc_e;
    assign bus.pc4_e      = r_pc4_e;
    assign bus.imm_e      = r_imm_e;
    assign bus.rd_e1      = r_rd_e1;
    assign bus.rd_e2      = r_rd_e2;
    assign bus.rs_e1      = r_rs_e1;
    assign bus.rs_e2      = r_rs_e2;
    assign bus.rd_e       = r_rd_e;
    assign bus.ctrl_e     = r_ctrl_e;
    assign bus.load_e     = r_load_e;
    assign bus.bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Parametrised decode-to-execute stage for the RV32I pipeline.
- Holds the integer register file with write-back-to-decode bypass.
- Detects load-use hazards and inserts bubbles.
- Registers decoded operands, immediate, PCs and a packed control bundle into the execute stage.
- Honours downstream stall and branch/jump flush, tracks per-stage valid, and counts inserted bubbles.

Parameters:
XLEN, 32, datapath width (operands, immediate, PC)
NREG, 32, architectural register count; entry 0 reads as zero
AW, $clog2(NREG), register address width
CTRL_W, 16, width of packed control bundle from control unit
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
valid_d  in  1  decode-stage instruction valid
pc_d  in  XLEN  decode PC
pc4_d  in  XLEN  decode PC+4
rs1_d  in  AW  source register 1 index
rs2_d  in  AW  source register 2 index
rd_d  in  AW  destination index
uses_rs1_d  in  1  instruction reads rs1
uses_rs2_d  in  1  instruction reads rs2
imm_d  in  XLEN  selected immediate
ctrl_d  in  CTRL_W  packed control bundle
load_d  in  1  instruction is a load
wb_en  in  1  write-back enable
wb_addr  in  AW  write-back index
wb_data  in  XLEN  write-back data
stall  in  1  downstream hold request
flush  in  1  kill execute-stage content (taken branch/jump)
ready_d  out  1  decode instruction accepted this cycle
hazard  out  1  load-use hazard detected (combinational)
valid_e, pc_e, pc4_e, imm_e, rd_e1, rd_e2, rs_e1, rs_e2, rd_e, ctrl_e, load_e  out  registered execute-stage copies (widths as inputs)
bubble_cnt  out  CNT_W  hazard bubbles inserted

Behaviour:
- Reset (rst=0, async): every register-file entry and every output register = 0, including bubble_cnt. Release is synchronous to clk.
- Register file, write path: on clk edge, write when wb_en=1 and wb_addr!=0. Writes occur regardless of stall, flush or hazard.
- Register file, read path: combinational. Index 0 returns 0.
  - Bypass: if wb_en=1 and wb_addr==rsN_d and rsN_d!=0, the read returns wb_data (write-first).
- hazard = valid_d & valid_e & load_e & (rd_e!=0) & ((uses_rs1_d & rs1_d==rd_e) | (uses_rs2_d & rs2_d==rd_e)).
- ready_d = ~stall & ~hazard & ~flush. Upstream holds decode when ready_d=0.
- Execute-register update priority, highest first:
  1. flush=1: valid_e=0, ctrl_e=0, load_e=0; data fields zeroed.
  2. stall=1: all execute registers hold.
  3. hazard=1: bubble loaded (as flush); bubble_cnt+1.
  4. otherwise: load all decode fields.
     - valid_e=valid_d.
     - If valid_d=0, ctrl_e=0 and load_e=0; data fields still loaded.
- Latency: one cycle decode-to-execute. Bypassed write-back is visible in the same cycle.
- A held hazard (stall & hazard) does not count. Flush during hazard does not count.
- bubble_cnt saturates at 2^CNT_W-1; no wrap.
- Reset mid-operation: outputs clear immediately and asynchronously; no partial update on the following edge.
- Simultaneous wb write to rd_e and hazard: the hazard is still raised. The bypass only resolves write-back, not load-in-execute.

Test Plan:
1. Reset/pass-through: rst=0 -> all outputs 0. Release; write x5=0x1234, then valid_d=1, rs1_d=5, imm_d=0xFFFFFFF0, ctrl_d=0x00A5 -> next cycle rd_e1=0x1234, imm_e=0xFFFFFFF0, ctrl_e=0x00A5, valid_e=1.
2. Bypass/x0: wb_en=1, wb_addr=7, wb_data=0xDEADBEEF, same cycle rs2_d=7 -> rd_e2=0xDEADBEEF next cycle. Write wb_addr=0 with 0xFFFFFFFF -> reading rs1_d=0 gives rd_e1=0.
3. Load-use: execute holds load with rd_e=3; decode uses_rs1_d=1, rs1_d=3 -> hazard=1, ready_d=0. Next cycle valid_e=0, ctrl_e=0, bubble_cnt=1. Following cycle the instruction loads, bubble_cnt stays 1.
4. Priority: flush=1 with stall=1 and hazard=1 -> valid_e=0, bubble_cnt unchanged. Then stall=1 alone for 3 cycles -> all execute outputs hold.
5. Saturation: CNT_W=2, force 5 hazard bubbles -> bubble_cnt sequence 1,2,3,3,3.
6. Async reset mid-stream: drop rst between edges while valid_e=1 -> valid_e=0 and bubble_cnt=0 before the next clk edge; register file reads 0.
